// File: rtl/pic_priority_controller_n.sv
// -----------------------------------------------------------------------------
// pic_priority_controller_n
//
// Rotating-priority interrupt controller core in the style of an 8259. It
// collects NUM_IRQ request lines into an interrupt request register (IRR),
// resolves the highest pending unmasked request against the in-service
// register (ISR), raises INT to the CPU, and answers a two-pulse INTA#
// handshake with a vector on the second pulse.
//
// Ports
//   clock                          rising-edge system clock
//   reset_n                        asynchronous active-low reset
//   write_initial_command_word_1   one-cycle synchronous re-initialise pulse
//   level_or_edge_triggered_config 1 = level-sensitive IRR, 0 = edge-sensitive
//   auto_eoi_config                clear ISR bit automatically at end of INTA
//   auto_rotate_mode               rotate priority on automatic EOI
//   vector_base                    upper vector bits (low ID_WIDTH ignored)
//   interrupt_request              synchronous IR lines
//   interrupt_mask                 1 = channel masked (stays pending in IRR)
//   write_eoi                      end-of-interrupt command pulse
//   eoi_specific                   1 = clear ISR[eoi_level], 0 = highest set
//   eoi_rotate                     load lowest priority with the cleared level
//   eoi_level                      level for a specific EOI
//   interrupt_acknowledge_n        synchronised INTA#
//   interrupt_to_cpu               INT request to the CPU
//   vector_out                     vector, valid while vector_enable = 1
//   vector_enable                  data-bus drive qualifier
//   interrupt_request_register     IRR
//   in_service_register            ISR
//   spurious_interrupt             one-cycle pulse on acknowledge with no
//                                  serviceable request
// -----------------------------------------------------------------------------
module pic_priority_controller_n #(
  parameter int NUM_IRQ      = 8,
  parameter int VECTOR_WIDTH = 8,
  localparam int ID_WIDTH    = $clog2(NUM_IRQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    write_initial_command_word_1,
  input  logic                    level_or_edge_triggered_config,
  input  logic                    auto_eoi_config,
  input  logic                    auto_rotate_mode,
  input  logic [VECTOR_WIDTH-1:0] vector_base,
  input  logic [NUM_IRQ-1:0]      interrupt_request,
  input  logic [NUM_IRQ-1:0]      interrupt_mask,
  input  logic                    write_eoi,
  input  logic                    eoi_specific,
  input  logic                    eoi_rotate,
  input  logic [ID_WIDTH-1:0]     eoi_level,
  input  logic                    interrupt_acknowledge_n,
  output logic                    interrupt_to_cpu,
  output logic [VECTOR_WIDTH-1:0] vector_out,
  output logic                    vector_enable,
  output logic [NUM_IRQ-1:0]      interrupt_request_register,
  output logic [NUM_IRQ-1:0]      in_service_register,
  output logic                    spurious_interrupt
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

  // Result of a rotating priority search: rank 0 is the highest priority.
  typedef struct packed {
    logic                found;
    logic [ID_WIDTH-1:0] rank;
    logic [ID_WIDTH-1:0] id;
  } pick_t;

  localparam logic [ID_WIDTH-1:0] LOWEST_RESET = ID_WIDTH'(NUM_IRQ - 1);

  state_t                  state_reg, state_next;
  logic [NUM_IRQ-1:0]      irr_reg, irr_next;
  logic [NUM_IRQ-1:0]      isr_reg, isr_next;
  logic [ID_WIDTH-1:0]     lowest_reg, lowest_next;
  logic [ID_WIDTH-1:0]     ack_id_reg, ack_id_next;
  logic                    ack_spurious_reg, ack_spurious_next;
  logic                    int_reg, int_next;
  logic                    spurious_reg, spurious_next;
  logic                    vec_en_reg, vec_en_next;
  logic [VECTOR_WIDTH-1:0] vec_out_reg, vec_out_next;
  logic                    inta_prev_reg;
  logic [NUM_IRQ-1:0]      req_prev_reg;

  logic                    inta_fall;
  logic                    inta_rise;
  logic [NUM_IRQ-1:0]      irr_sampled;
  logic [NUM_IRQ-1:0]      irr_unmasked;
  pick_t                   cand;
  pick_t                   isr_pick;
  logic                    int_cond;
  logic                    vector_base_unused;

  // The low vector bits are replaced by the acknowledged channel id.
  assign vector_base_unused = ^vector_base[ID_WIDTH-1:0];

  // Scan levels starting just above 'lowest'; the last hit in a descending
  // loop is the one with the smallest rank, i.e. the highest priority.
  function automatic pick_t pick_highest(input logic [NUM_IRQ-1:0] vec,
                                         input logic [ID_WIDTH-1:0] lowest);
    pick_t               p;
    logic [ID_WIDTH-1:0] idx;
    p   = '0;
    idx = '0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      idx = lowest + ID_WIDTH'(j) + ID_WIDTH'(1);
      if (vec[idx]) begin
        p.found = 1'b1;
        p.rank  = ID_WIDTH'(j);
        p.id    = idx;
      end
    end
    return p;
  endfunction

  assign inta_fall = inta_prev_reg & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev_reg & interrupt_acknowledge_n;

  // Per-channel IRR update when not frozen by an acknowledge cycle.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irr
    assign irr_sampled[gi] = level_or_edge_triggered_config
                             ? interrupt_request[gi]
                             : (irr_reg[gi] | (interrupt_request[gi] & ~req_prev_reg[gi]));
  end

  assign irr_unmasked = irr_reg & ~interrupt_mask;
  assign cand         = pick_highest(irr_unmasked, lowest_reg);
  assign isr_pick     = pick_highest(isr_reg, lowest_reg);
  // A request is serviceable only if it outranks everything in service.
  assign int_cond     = cand.found && (!isr_pick.found || (cand.rank < isr_pick.rank));

  always_comb begin
    state_next        = state_reg;
    irr_next          = irr_reg;
    isr_next          = isr_reg;
    lowest_next       = lowest_reg;
    ack_id_next       = ack_id_reg;
    ack_spurious_next = ack_spurious_reg;
    int_next          = 1'b0;
    spurious_next     = 1'b0;
    vec_en_next       = vec_en_reg;
    vec_out_next      = vec_out_reg;

    // EOI clears are applied first so that an acknowledge setting the same
    // ISR bit in this cycle overrides them.
    if (write_eoi) begin
      if (eoi_specific) begin
        isr_next[eoi_level] = 1'b0;
        if (eoi_rotate) lowest_next = eoi_level;
      end else if (isr_pick.found) begin
        isr_next[isr_pick.id] = 1'b0;
        if (eoi_rotate) lowest_next = isr_pick.id;
      end
    end

    unique case (state_reg)
      IDLE: begin
        irr_next = irr_sampled;
        int_next = int_cond;
        if (inta_fall) begin
          state_next = ACK1;
          int_next   = 1'b0;
          irr_next   = irr_reg;     // IRR is frozen from the latch cycle on
          if (int_cond) begin
            ack_id_next        = cand.id;
            ack_spurious_next  = 1'b0;
            isr_next[cand.id]  = 1'b1;
            irr_next[cand.id]  = 1'b0;
          end else begin
            ack_id_next       = LOWEST_RESET;
            ack_spurious_next = 1'b1;
            spurious_next     = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_next = ACK2;
      end
      ACK2: begin
        if (inta_fall) begin
          vec_en_next  = 1'b1;
          vec_out_next = {vector_base[VECTOR_WIDTH-1:ID_WIDTH], ack_id_reg};
        end else if (inta_rise) begin
          state_next   = IDLE;
          vec_en_next  = 1'b0;
          vec_out_next = '0;
          if (auto_eoi_config && !ack_spurious_reg) begin
            isr_next[ack_id_reg] = 1'b0;
            if (auto_rotate_mode) lowest_next = ack_id_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (write_initial_command_word_1) begin
      state_next        = IDLE;
      irr_next          = '0;
      isr_next          = '0;
      lowest_next       = LOWEST_RESET;
      ack_id_next       = '0;
      ack_spurious_next = 1'b0;
      int_next          = 1'b0;
      spurious_next     = 1'b0;
      vec_en_next       = 1'b0;
      vec_out_next      = '0;
    end
  end

  // Edge history resets to all-ones: a line already high at (re)initialise
  // must fall and rise again before it is latched in edge mode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      irr_reg          <= '0;
      isr_reg          <= '0;
      lowest_reg       <= LOWEST_RESET;
      ack_id_reg       <= '0;
      ack_spurious_reg <= 1'b0;
      int_reg          <= 1'b0;
      spurious_reg     <= 1'b0;
      vec_en_reg       <= 1'b0;
      vec_out_reg      <= '0;
      inta_prev_reg    <= 1'b1;
      req_prev_reg     <= '1;
    end else begin
      state_reg        <= state_next;
      irr_reg          <= irr_next;
      isr_reg          <= isr_next;
      lowest_reg       <= lowest_next;
      ack_id_reg       <= ack_id_next;
      ack_spurious_reg <= ack_spurious_next;
      int_reg          <= int_next;
      spurious_reg     <= spurious_next;
      vec_en_reg       <= vec_en_next;
      vec_out_reg      <= vec_out_next;
      inta_prev_reg    <= write_initial_command_word_1 ? 1'b1 : interrupt_acknowledge_n;
      req_prev_reg     <= write_initial_command_word_1 ? '1 : interrupt_request;
    end
  end

  assign interrupt_to_cpu           = int_reg;
  assign vector_out                 = vec_out_reg;
  assign vector_enable              = vec_en_reg;
  assign interrupt_request_register = irr_reg;
  assign in_service_register        = isr_reg;
  assign spurious_interrupt         = spurious_reg;

endmodule

// File: tb/tb_pic_priority_controller_n.sv
// -----------------------------------------------------------------------------
// Bench for pic_priority_controller_n: an 8-channel instance driven by directed
// scenarios and randomised request/mask/EOI traffic checked against a
// transaction-level priority model, plus a 16-channel instance for the
// masking and wide-id vector case.
// -----------------------------------------------------------------------------
module tb_pic_priority_controller_n;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       icw1 = 1'b0;
  logic       level_cfg = 1'b0;
  logic       auto_eoi = 1'b0;
  logic       auto_rot = 1'b0;
  logic [7:0] vector_base = 8'h40;
  logic [7:0] interrupt_request = 8'h00;
  logic [7:0] interrupt_mask = 8'h00;
  logic       write_eoi = 1'b0;
  logic       eoi_specific = 1'b0;
  logic       eoi_rotate = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       inta_n = 1'b1;
  logic       int_cpu;
  logic [7:0] vector_out;
  logic       vector_enable;
  logic [7:0] irr;
  logic [7:0] isr;
  logic       spurious;

  // 16-channel instance
  logic        b_icw1 = 1'b0;
  logic [15:0] b_req = 16'h0000;
  logic [15:0] b_mask = 16'h0000;
  logic        b_inta_n = 1'b1;
  logic        b_int;
  logic [7:0]  b_vec;
  logic        b_vec_en;
  logic [15:0] b_irr;
  logic [15:0] b_isr;
  logic        b_spur;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] m_irr = 8'h00;
  logic [7:0] m_isr = 8'h00;
  int         m_low = 7;
  logic [7:0] cur_req = 8'h00;

  always #5 clock = ~clock;

  pic_priority_controller_n #(.NUM_IRQ(8), .VECTOR_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .write_initial_command_word_1(icw1),
    .level_or_edge_triggered_config(level_cfg),
    .auto_eoi_config(auto_eoi), .auto_rotate_mode(auto_rot),
    .vector_base(vector_base),
    .interrupt_request(interrupt_request), .interrupt_mask(interrupt_mask),
    .write_eoi(write_eoi), .eoi_specific(eoi_specific),
    .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .interrupt_acknowledge_n(inta_n),
    .interrupt_to_cpu(int_cpu), .vector_out(vector_out),
    .vector_enable(vector_enable),
    .interrupt_request_register(irr), .in_service_register(isr),
    .spurious_interrupt(spurious)
  );

  pic_priority_controller_n #(.NUM_IRQ(16), .VECTOR_WIDTH(8)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .write_initial_command_word_1(b_icw1),
    .level_or_edge_triggered_config(1'b0),
    .auto_eoi_config(1'b0), .auto_rotate_mode(1'b0),
    .vector_base(8'h40),
    .interrupt_request(b_req), .interrupt_mask(b_mask),
    .write_eoi(1'b0), .eoi_specific(1'b0),
    .eoi_rotate(1'b0), .eoi_level(4'd0),
    .interrupt_acknowledge_n(b_inta_n),
    .interrupt_to_cpu(b_int), .vector_out(b_vec),
    .vector_enable(b_vec_en),
    .interrupt_request_register(b_irr), .in_service_register(b_isr),
    .spurious_interrupt(b_spur)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Highest-priority set bit: levels are visited in order low+1, low+2, ...
  function automatic int m_best(input logic [7:0] v);
    for (int k = 1; k <= 8; k++) begin
      int id;
      id = (m_low + k) % 8;
      if (v[id]) return id;
    end
    return -1;
  endfunction

  function automatic int m_rank(input int id);
    return (id - m_low - 1 + 16) % 8;
  endfunction

  function automatic bit m_int();
    int c;
    int s;
    c = m_best(m_irr & ~interrupt_mask);
    s = m_best(m_isr);
    if (c < 0) return 1'b0;
    if (s < 0) return 1'b1;
    return m_rank(c) < m_rank(s);
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_irr"}, irr, m_irr);
    check({tag, "_isr"}, isr, m_isr);
    check({tag, "_int"}, int_cpu, m_int());
    $display("txn %s irr=%02h isr=%02h int=%0b", tag, irr, isr, int_cpu);
  endtask

  // Edge mode: a bit is latched when its line goes 0->1.
  task automatic set_req(input logic [7:0] bits);
    m_irr = m_irr | (bits & ~cur_req);
    cur_req = bits;
    interrupt_request = bits;
    step();
  endtask

  task automatic model_reset();
    m_irr = 8'h00;
    m_isr = 8'h00;
    m_low = 7;
  endtask

  task automatic do_ack(input string tag, output logic [7:0] vobs);
    int         c;
    bit         valid;
    logic [7:0] vexp;
    valid = m_int();
    c = valid ? m_best(m_irr & ~interrupt_mask) : 7;
    vexp = (vector_base & 8'hF8) | 8'(c);
    inta_n = 1'b0; step();
    check({tag, "_spur"}, spurious, valid ? 1'b0 : 1'b1);
    check({tag, "_intdrop"}, int_cpu, 1'b0);
    if (valid) begin
      m_isr[c] = 1'b1;
      m_irr[c] = 1'b0;
    end
    check({tag, "_ack1_irr"}, irr, m_irr);
    check({tag, "_ack1_isr"}, isr, m_isr);
    inta_n = 1'b1; step();
    check({tag, "_ack1_ven"}, vector_enable, 1'b0);
    inta_n = 1'b0; step();
    check({tag, "_ack2_ven"}, vector_enable, 1'b1);
    vobs = vector_out;
    check({tag, "_vec"}, vector_out, vexp);
    inta_n = 1'b1; step();
    check({tag, "_end_ven"}, vector_enable, 1'b0);
    check({tag, "_end_vec"}, vector_out, 8'h00);
    if (valid && auto_eoi) begin
      m_isr[c] = 1'b0;
      if (auto_rot) m_low = c;
    end
    $display("txn %s ack vector=%02h spurious_expected=%0b", tag, vobs, !valid);
    step();
    check_state(tag);
  endtask

  task automatic do_eoi(input string tag, input bit spec, input bit rot, input int lvl);
    int b;
    if (spec) begin
      m_isr[lvl] = 1'b0;
      if (rot) m_low = lvl;
    end else begin
      b = m_best(m_isr);
      if (b >= 0) begin
        m_isr[b] = 1'b0;
        if (rot) m_low = b;
      end
    end
    write_eoi = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = 3'(lvl);
    step();
    write_eoi = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
    step();
    check_state(tag);
  endtask

  initial begin
    logic [7:0] v;

    // Reset state, checked while reset is still asserted
    #2;
    check("rst_int", int_cpu, 1'b0);
    check("rst_ven", vector_enable, 1'b0);
    check("rst_vec", vector_out, 8'h00);
    check("rst_spur", spurious, 1'b0);
    step(); step();
    reset_n = 1'b1;
    step();
    check_state("reset");

    // IR3 edge: IRR at the first edge, INT one edge later, vector 0x43
    set_req(8'h08);
    check("r33_irr", irr, 8'h08);
    check("r33_int_early", int_cpu, 1'b0);
    step();
    check("r33_int", int_cpu, 1'b1);
    do_ack("r33", v);
    check("r33_vec_const", v, 8'h43);
    check("r33_isr_const", isr, 8'h08);
    do_eoi("r33_eoi", 1'b0, 1'b0, 0);

    // IR5 and IR2 together: IR2 first, IR5 after a non-specific EOI
    set_req(8'h00);
    set_req(8'h24);
    step();
    check_state("r34_pend");
    do_ack("r34a", v);
    check("r34a_vec_const", v, 8'h42);
    check("r34_int_blocked", int_cpu, 1'b0);
    do_eoi("r34_eoi", 1'b0, 1'b0, 0);
    do_ack("r34b", v);
    check("r34b_vec_const", v, 8'h45);
    do_eoi("r34b_eoi", 1'b0, 1'b0, 0);

    // Acknowledge with nothing pending
    do_ack("r36", v);
    check("r36_vec_const", v, 8'h47);
    check("r36_isr_const", isr, 8'h00);

    // Level mode: IRR follows the line
    set_req(8'h00);
    level_cfg = 1'b1;
    interrupt_request = 8'h40; step();
    check("lvl_irr_hi", irr, 8'h40);
    step();
    check("lvl_int_hi", int_cpu, 1'b1);
    interrupt_request = 8'h00; step();
    check("lvl_irr_lo", irr, 8'h00);
    step();
    check("lvl_int_lo", int_cpu, 1'b0);
    level_cfg = 1'b0;
    step();

    // Automatic EOI with rotation
    auto_eoi = 1'b1; auto_rot = 1'b1;
    set_req(8'h01); step();
    do_ack("r35a", v);
    check("r35a_vec_const", v, 8'h40);
    check("r35a_isr_const", isr, 8'h00);
    set_req(8'h00);
    set_req(8'h02); step();
    do_ack("r35b", v);
    check("r35b_vec_const", v, 8'h41);
    check("r35b_isr_const", isr, 8'h00);
    set_req(8'h00);
    set_req(8'h03); step();
    do_ack("r35c", v);
    check("r35c_vec_const", v, 8'h40);
    do_ack("r35d", v);
    check("r35d_vec_const", v, 8'h41);
    auto_eoi = 1'b0; auto_rot = 1'b0;
    set_req(8'h00);

    // Re-initialise in the middle of an acknowledge
    set_req(8'h02); step();
    inta_n = 1'b0; step();
    icw1 = 1'b1; inta_n = 1'b1; interrupt_request = 8'h00; cur_req = 8'h00;
    step();
    icw1 = 1'b0;
    model_reset();
    step();
    check_state("icw1");
    check("icw1_ven", vector_enable, 1'b0);

    // Asynchronous reset during ACK2
    set_req(8'h08); step();
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    check("r37_ven_before", vector_enable, 1'b1);
    reset_n = 1'b0;
    #1;
    check("r37_ven_async", vector_enable, 1'b0);
    check("r37_isr_async", isr, 8'h00);
    check("r37_irr_async", irr, 8'h00);
    inta_n = 1'b1; interrupt_request = 8'h00; cur_req = 8'h00;
    model_reset();
    step();
    reset_n = 1'b1;
    step();
    set_req(8'h10); step();
    do_ack("r37", v);
    check("r37_vec_const", v, 8'h44);
    do_eoi("r37_eoi", 1'b0, 1'b0, 0);

    // Randomised traffic against the model
    for (int it = 0; it < 40; it++) begin
      interrupt_mask = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      set_req(8'h00);
      set_req(8'($urandom_range(0, 255)));
      step();
      check_state("rnd_pend");
      if ($urandom_range(0, 3) != 0) do_ack("rnd_ack", v);
      if ($urandom_range(0, 1) == 1)
        do_eoi("rnd_eoi", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)));
    end
    interrupt_mask = 8'h00;

    // 16 channels: IR15 masked, then unmasked
    b_mask = 16'h8000;
    b_req = 16'h8000; step(); step(); step();
    check("r38_irr_masked", b_irr, 16'h8000);
    check("r38_int_masked", b_int, 1'b0);
    b_mask = 16'h0000; step();
    check("r38_int_unmask", b_int, 1'b1);
    b_inta_n = 1'b0; step();
    check("r38_isr", b_isr, 16'h8000);
    check("r38_spur", b_spur, 1'b0);
    b_inta_n = 1'b1; step();
    b_inta_n = 1'b0; step();
    check("r38_ven", b_vec_en, 1'b1);
    check("r38_vec", b_vec, 8'h4F);
    $display("txn r38 ack vector=%02h", b_vec);
    b_inta_n = 1'b1; step();
    check("r38_ven_end", b_vec_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
